shift_unit_seq: RTL

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

---
 rtl/shifter_pkg.sv | 34 +++
 rtl/shift_step.sv | 53 +++++
 rtl/shift_unit_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// ============================================================================
//  Module      : shifter_pkg
//  Description : Shared mode and state encodings for the sequential shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    localparam logic [2:0] c_mode_pass = 3'd0;
    localparam logic [2:0] c_mode_lsr  = 3'd1;
    localparam logic [2:0] c_mode_lsl  = 3'd2;
    localparam logic [2:0] c_mode_asr  = 3'd3;
    localparam logic [2:0] c_mode_ror  = 3'd4;
    localparam logic [2:0] c_mode_rol  = 3'd5;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_SHIFT = c_st_shift,
        ST_DONE  = c_st_done
    } state_t;

    // Modes 0, 6 and 7 pass the operand through untouched.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= c_mode_lsr) && (mode <= c_mode_rol);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-bit shift/rotate step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            c_mode_lsr: begin
                next_value = {fill, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            c_mode_lsl: begin
                next_value = {value[WIDTH-2:0], fill};
                out_bit    = value[WIDTH-1];
            end
            c_mode_asr: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            c_mode_ror: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            c_mode_rol: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_unit_seq.sv
// ============================================================================
//  Module      : shift_unit_seq
//  Description : Multi-cycle shifter, one bit per clock, with done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic             in_l,
    input  logic             in_r,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             zero
);

    localparam logic [AMT_W:0] c_width_ext = (AMT_W+1)'(WIDTH);

    state_t            r_state;
    state_t            w_next_state;
    logic [AMT_W-1:0]  r_count;
    logic [2:0]        r_mode;
    logic              r_fill;
    logic [WIDTH-1:0]  r_dout;
    logic              r_cout;

    logic [AMT_W-1:0]  w_amt_sat;
    logic              w_fill;
    logic [WIDTH-1:0]  w_step_value;
    logic              w_step_out;

    // Only reachable for non-power-of-two widths.
    assign w_amt_sat = ({1'b0, amount} >= c_width_ext) ? AMT_W'(WIDTH - 1) : amount;
    assign w_fill    = (mode == c_mode_lsl) ? in_r : in_l;

    shift_step #(
        .WIDTH      (WIDTH)
    ) u_shift_step (
        .value      (r_dout),
        .mode       (r_mode),
        .fill       (r_fill),
        .next_value (w_step_value),
        .out_bit    (w_step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ((w_amt_sat == '0) || !is_shift_mode(mode)) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == AMT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_mode  <= c_mode_pass;
            r_fill  <= 1'b0;
            r_dout  <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dout  <= din;
                        r_mode  <= mode;
                        r_fill  <= w_fill;
                        r_count <= w_amt_sat;
                        r_cout  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_dout  <= w_step_value;
                    r_cout  <= w_step_out;
                    r_count <= r_count - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign dout = r_dout;
    assign cout = r_cout;
    assign zero = (r_dout == '0);

endmodule

`default_nettype wire
